fg_multichannel_burst_gen: RTL and testbench

//   Multi-channel successor of the single-channel function generator: CHANNELS independent waveform

---
 rtl/fg_multichannel_burst_gen.sv | 190 +++++++++++++++++++
 tb/tb_fg_multichannel_burst_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fg_multichannel_burst_gen.sv
// Multi-channel burst function generator: independent constant/square/saw/triangle engines
// with per-channel prescaler, period and burst control, plus a saturated mix of all channels.
module fg_multichannel_burst_gen #(
  parameter int BITWIDTH           = 8,
  parameter int BITWIDTH_PRESCALER = 6,
  parameter int BITWIDTH_TIMER     = 8,
  parameter int BITWIDTH_BURST     = 8,
  parameter int CHANNELS           = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  input  logic                                  enable_i,
  input  logic [CHANNELS-1:0]                   start_i,
  input  logic [CHANNELS-1:0]                   stop_i,
  input  logic [CHANNELS*(3+BITWIDTH_BURST+BITWIDTH_PRESCALER+2*BITWIDTH_TIMER+3*BITWIDTH)-1:0] CR_bus_i,
  output logic [CHANNELS*BITWIDTH-1:0]          out_o,
  output logic [CHANNELS-1:0]                   outValid_STRB_o,
  output logic [BITWIDTH-1:0]                   mix_o,
  output logic                                  mixValid_STRB_o,
  output logic [CHANNELS-1:0]                   busy_o,
  output logic [CHANNELS-1:0]                   done_o
);
  localparam int BW   = BITWIDTH;
  localparam int PW   = BITWIDTH_PRESCALER;
  localparam int TW   = BITWIDTH_TIMER;
  localparam int BRW  = BITWIDTH_BURST;
  localparam int CR_W = 3 + BRW + PW + 2*TW + 3*BW;
  localparam int SW   = BW + 2;
  localparam int MW   = BW + $clog2(CHANNELS) + 1;

  localparam logic signed [SW-1:0] S_MAX = {3'b000, {(BW-1){1'b1}}};
  localparam logic signed [SW-1:0] S_MIN = {3'b111, {(BW-1){1'b0}}};
  localparam logic signed [MW-1:0] M_MAX = {{(MW-BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [MW-1:0] M_MIN = {{(MW-BW+1){1'b1}}, {(BW-1){1'b0}}};
  localparam logic [PW-1:0]  PSC_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]  CNT_ONE   = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [BRW-1:0] BURST_ONE = {{(BRW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [CR_W-1:0] cfg_r;
    state_t          state_r;
    logic [PW-1:0]   psc_r;
    logic [TW-1:0]   cnt_r;
    logic [BW-1:0]   acc_r;
    logic [BRW-1:0]  burst_r;
    logic [BW-1:0]   out_r;
    logic            valid_r;

    logic [BW-1:0]  offset_s, amplitude_s, step_s;
    logic [TW-1:0]  on_count_s, period_s;
    logic [PW-1:0]  prescaler_s;
    logic [BRW-1:0] burst_len_s;
    logic [2:0]     mode_s;
    logic           tick_s;

    assign offset_s    = cfg_r[0 +: BW];
    assign amplitude_s = cfg_r[BW +: BW];
    assign step_s      = cfg_r[2*BW +: BW];
    assign on_count_s  = cfg_r[3*BW +: TW];
    assign period_s    = cfg_r[3*BW+TW +: TW];
    assign prescaler_s = cfg_r[3*BW+2*TW +: PW];
    assign burst_len_s = cfg_r[3*BW+2*TW+PW +: BRW];
    assign mode_s      = cfg_r[CR_W-3 +: 3];
    assign tick_s      = (state_r == S_RUN) && enable_i && (psc_r == prescaler_s);

    logic [BW-1:0]        wave_s, acc_up_s, acc_dn_s, sample_s;
    logic [BW:0]          acc_sum_s;
    logic signed [SW-1:0] sum_s;

    // Waveform value from current cnt/acc, saturated offset add and next accumulator candidates
    always_comb begin
      wave_s    = {BW{1'b0}};
      acc_sum_s = {1'b0, acc_r} + {1'b0, step_s};
      acc_up_s  = (acc_sum_s > {1'b0, amplitude_s}) ? amplitude_s : acc_sum_s[BW-1:0];
      acc_dn_s  = (acc_r > step_s) ? (acc_r - step_s) : {BW{1'b0}};
      case (mode_s)
        3'd0:    wave_s = amplitude_s;
        3'd1:    wave_s = (cnt_r < on_count_s) ? amplitude_s : {BW{1'b0}};
        3'd2:    wave_s = acc_r;
        3'd3:    wave_s = acc_r;
        default: wave_s = {BW{1'b0}};
      endcase
      sum_s = $signed({2'b00, wave_s}) + $signed({{2{offset_s[BW-1]}}, offset_s});
      if (sum_s > S_MAX) begin
        sample_s = S_MAX[BW-1:0];
      end else if (sum_s < S_MIN) begin
        sample_s = S_MIN[BW-1:0];
      end else begin
        sample_s = sum_s[BW-1:0];
      end
    end

    // Channel FSM, counters and registered sample; stop has priority over start
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        cfg_r   <= {CR_W{1'b0}};
        state_r <= S_IDLE;
        psc_r   <= {PW{1'b0}};
        cnt_r   <= {TW{1'b0}};
        acc_r   <= {BW{1'b0}};
        burst_r <= {BRW{1'b0}};
        out_r   <= {BW{1'b0}};
        valid_r <= 1'b0;
      end else begin
        valid_r <= 1'b0;
        if (stop_i[n]) begin
          state_r <= S_IDLE;
        end else if (start_i[n]) begin
          cfg_r   <= CR_bus_i[n*CR_W +: CR_W];
          state_r <= S_RUN;
          psc_r   <= {PW{1'b0}};
          cnt_r   <= {TW{1'b0}};
          acc_r   <= {BW{1'b0}};
          burst_r <= {BRW{1'b0}};
        end else if (tick_s) begin
          out_r   <= sample_s;
          valid_r <= 1'b1;
          psc_r   <= {PW{1'b0}};
          if (cnt_r == period_s) begin
            cnt_r   <= {TW{1'b0}};
            acc_r   <= {BW{1'b0}};
            burst_r <= burst_r + BURST_ONE;
            if ((burst_len_s != {BRW{1'b0}}) && ((burst_r + BURST_ONE) == burst_len_s)) begin
              state_r <= S_DONE;
            end else begin
              state_r <= state_r;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (mode_s == 3'd2) begin
              acc_r <= acc_up_s;
            end else if (mode_s == 3'd3) begin
              acc_r <= (cnt_r < on_count_s) ? acc_up_s : acc_dn_s;
            end else begin
              acc_r <= acc_r;
            end
          end
        end else if ((state_r == S_RUN) && enable_i) begin
          psc_r <= psc_r + PSC_ONE;
        end else begin
          psc_r <= psc_r;
        end
      end
    end

    assign out_o[n*BW +: BW] = out_r;
    assign outValid_STRB_o[n] = valid_r;
    assign busy_o[n] = (state_r == S_RUN);
    assign done_o[n] = (state_r == S_DONE);
  end

  logic signed [MW-1:0] mix_sum_s;
  logic [BW-1:0]        mix_sat_s;
  logic [BW-1:0]        mix_r;
  logic                 mix_valid_r;

  // Sign-extended sum of all channel samples, clamped to the sample range
  always_comb begin
    mix_sum_s = {MW{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      mix_sum_s = mix_sum_s + $signed({{(MW-BW){out_o[i*BW+BW-1]}}, out_o[i*BW +: BW]});
    end
    if (mix_sum_s > M_MAX) begin
      mix_sat_s = M_MAX[BW-1:0];
    end else if (mix_sum_s < M_MIN) begin
      mix_sat_s = M_MIN[BW-1:0];
    end else begin
      mix_sat_s = mix_sum_s[BW-1:0];
    end
  end

  // Mix register refreshes the cycle after any channel strobe
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mix_r       <= {BW{1'b0}};
      mix_valid_r <= 1'b0;
    end else if (|outValid_STRB_o) begin
      mix_r       <= mix_sat_s;
      mix_valid_r <= 1'b1;
    end else begin
      mix_r       <= mix_r;
      mix_valid_r <= 1'b0;
    end
  end

  assign mix_o           = mix_r;
  assign mixValid_STRB_o = mix_valid_r;
endmodule

// File: tb/tb_fg_multichannel_burst_gen.sv
// Directed self-checking bench for fg_multichannel_burst_gen with two channels at default widths.
module tb_fg_multichannel_burst_gen;
  localparam int CR_W = 57;

  logic           clk_i = 1'b0;
  logic           rstn_i;
  logic           enable_i;
  logic [1:0]     start_i, stop_i;
  logic [2*CR_W-1:0] CR_bus_i;
  logic [15:0]    out_o;
  logic [1:0]     outValid_STRB_o;
  logic [7:0]     mix_o;
  logic           mixValid_STRB_o;
  logic [1:0]     busy_o, done_o;

  int err_cnt = 0;
  int chk_cnt = 0;

  fg_multichannel_burst_gen dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i),
    .start_i(start_i), .stop_i(stop_i), .CR_bus_i(CR_bus_i),
    .out_o(out_o), .outValid_STRB_o(outValid_STRB_o),
    .mix_o(mix_o), .mixValid_STRB_o(mixValid_STRB_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CR_W-1:0] mk_cfg(input logic [2:0] mode, input logic [7:0] blen,
      input logic [5:0] psc, input logic [7:0] per, input logic [7:0] on,
      input logic [7:0] stp, input logic [7:0] amp, input logic [7:0] off);
    return {mode, blen, psc, per, on, stp, amp, off};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_ch(input int ch, input logic [CR_W-1:0] cfg);
    CR_bus_i[ch*CR_W +: CR_W] = cfg;
    start_i[ch] = 1'b1;
    step();
    start_i = 2'b00;
  endtask

  function automatic int s0();
    return int'($signed(out_o[7:0]));
  endfunction

  int t1[4] = '{100, 100, 0, 0};
  int t2[4] = '{0, 40, 80, 100};
  int t3[6] = '{0, 50, 100, 100, 50, 0};
  int exp_out;
  int strobes;

  initial begin
    rstn_i = 1'b0; enable_i = 1'b1; start_i = 2'b00; stop_i = 2'b00; CR_bus_i = '0;
    step(); step();
    check_val("rst_out", int'(out_o), 0);
    check_val("rst_busy", int'(busy_o), 0);
    check_val("rst_mix", int'(mix_o), 0);
    rstn_i = 1'b1;
    step();

    // T1 square, strobe every cycle, mix follows one cycle later
    start_ch(0, mk_cfg(3'd1, 8'd0, 6'd0, 8'd3, 8'd2, 8'd0, 8'd100, 8'd0));
    for (int i = 0; i < 8; i++) begin
      step();
      check_val("t1_out", s0(), t1[i % 4]);
      check_val("t1_vld", int'(outValid_STRB_o[0]), 1);
      if (i >= 1) begin
        check_val("t1_mix", int'($signed(mix_o)), t1[(i-1) % 4]);
        check_val("t1_mixv", int'(mixValid_STRB_o), 1);
      end
    end
    check_val("t1_busy", int'(busy_o), 1);

    // T2 sawtooth with prescaler 2, output holds between strobes
    exp_out = 0;
    start_ch(0, mk_cfg(3'd2, 8'd0, 6'd2, 8'd3, 8'd0, 8'd40, 8'd100, 8'd0));
    for (int i = 0; i < 12; i++) begin
      step();
      if (i % 3 == 2) exp_out = t2[i / 3];
      check_val("t2_vld", int'(outValid_STRB_o[0]), (i % 3 == 2) ? 1 : 0);
      check_val("t2_out", s0(), exp_out);
    end

    // T3 triangle, started as a restart of the running channel
    start_ch(0, mk_cfg(3'd3, 8'd0, 6'd0, 8'd5, 8'd3, 8'd50, 8'd100, 8'd0));
    for (int i = 0; i < 12; i++) begin
      step();
      check_val("t3_out", s0(), t3[i % 6]);
    end

    // T4 offset saturation and mix saturation
    start_ch(0, mk_cfg(3'd0, 8'd0, 6'd0, 8'd3, 8'd0, 8'd0, 8'd100, 8'd50));
    step();
    check_val("t4_pos_sat", s0(), 127);
    start_ch(0, mk_cfg(3'd0, 8'd0, 6'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'h80));
    step();
    check_val("t4_neg_sat", s0(), -128);
    CR_bus_i = {mk_cfg(3'd0, 8'd0, 6'd0, 8'd3, 8'd0, 8'd0, 8'd100, 8'd0),
                mk_cfg(3'd0, 8'd0, 6'd0, 8'd3, 8'd0, 8'd0, 8'd100, 8'd0)};
    start_i = 2'b11; step(); start_i = 2'b00;
    step();
    check_val("t4_ch1", int'($signed(out_o[15:8])), 100);
    step();
    check_val("t4_mix_pos", int'($signed(mix_o)), 127);
    CR_bus_i = {mk_cfg(3'd0, 8'd0, 6'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'h80),
                mk_cfg(3'd0, 8'd0, 6'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'h80)};
    start_i = 2'b11; step(); start_i = 2'b00;
    step(); step();
    check_val("t4_mix_neg", int'($signed(mix_o)), -128);
    stop_i = 2'b11; step(); stop_i = 2'b00;
    check_val("t4_stop", int'(busy_o), 0);

    // T5 burst of two periods then DONE
    strobes = 0;
    start_ch(0, mk_cfg(3'd1, 8'd2, 6'd0, 8'd3, 8'd2, 8'd0, 8'd100, 8'd0));
    for (int i = 0; i < 15; i++) begin
      step();
      strobes += int'(outValid_STRB_o[0]);
    end
    check_val("t5_strobes", strobes, 8);
    check_val("t5_busy", int'(busy_o[0]), 0);
    check_val("t5_done", int'(done_o[0]), 1);
    start_ch(0, mk_cfg(3'd1, 8'd2, 6'd0, 8'd3, 8'd2, 8'd0, 8'd100, 8'd0));
    check_val("t5_restart_done", int'(done_o[0]), 0);
    check_val("t5_restart_busy", int'(busy_o[0]), 1);
    for (int i = 0; i < 12; i++) step();
    check_val("t5_done2", int'(done_o[0]), 1);
    stop_i[0] = 1'b1; step(); stop_i = 2'b00;
    check_val("t5_stop_clr", int'(done_o[0]), 0);

    // T6 start and stop together: stop wins
    CR_bus_i[CR_W-1:0] = mk_cfg(3'd0, 8'd0, 6'd0, 8'd3, 8'd0, 8'd0, 8'd10, 8'd0);
    start_i[0] = 1'b1; stop_i[0] = 1'b1; step(); start_i = 2'b00; stop_i = 2'b00;
    check_val("t6_ss_busy", int'(busy_o[0]), 0);
    step();
    check_val("t6_ss_vld", int'(outValid_STRB_o[0]), 0);

    // T6 enable gap and config change mid-run
    start_ch(0, mk_cfg(3'd2, 8'd0, 6'd0, 8'd3, 8'd0, 8'd40, 8'd100, 8'd0));
    step(); check_val("t6_s0", s0(), 0);
    step(); check_val("t6_s1", s0(), 40);
    enable_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("t6_hold_vld", int'(outValid_STRB_o[0]), 0);
      check_val("t6_hold_out", s0(), 40);
    end
    enable_i = 1'b1;
    step(); check_val("t6_s2", s0(), 80);
    CR_bus_i[CR_W-1:0] = mk_cfg(3'd0, 8'd0, 6'd0, 8'd3, 8'd0, 8'd0, 8'd7, 8'd0);
    step(); check_val("t6_s3", s0(), 100);
    step(); check_val("t6_s4", s0(), 0);
    step(); check_val("t6_s5", s0(), 40);

    // T6 asynchronous reset mid-run
    #2 rstn_i = 1'b0;
    #1;
    check_val("t6_rst_out", int'(out_o), 0);
    check_val("t6_rst_busy", int'(busy_o), 0);
    check_val("t6_rst_vld", int'(outValid_STRB_o), 0);
    check_val("t6_rst_mix", int'(mix_o), 0);
    step();
    rstn_i = 1'b1;
    step();
    check_val("t6_post_vld", int'(outValid_STRB_o), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
